ccff_chain_loader: RTL and testbench

- Initiator end of the configuration-chain (ccff) protocol: accepts bitstream words from the host-side loader.
- Serialises each word onto the chain head, one bit per gated programming-clock cycle.
- Tracks the configured chain length and reports completion.
- Sits at fabric top, between the bitstream interface and the ccff_head of the first block in the chain. The last block's ccff_tail returns to it.

---
 rtl/ccff_loader_pkg.sv | 17 +
 rtl/ccff_word_serializer.sv | 41 ++++
 rtl/ccff_chain_loader.sv | 121 ++++++++++++
 tb/tb_ccff_chain_loader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared definitions for the configuration-chain loader: state encodings and
// the bit-counter width helper.
package ccff_loader_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FETCH = 2'd1;
    localparam state_t ST_SHIFT = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Wide enough to hold the value chain_len itself, not just chain_len-1.
    function automatic int cnt_width(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word-to-bit serializer: a right-shifting register whose LSB is the chain
// head flop, plus a bit index that flags the last bit of the current word.
module ccff_word_serializer #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              advance,
    input  logic              clear,
    input  logic [WORD_W-1:0] word,
    output logic              bit_out,
    output logic              last_bit
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] shreg;
    logic [IDX_W-1:0]  idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            idx   <= '0;
        end else if (clear) begin
            // Pass ended mid-word: drop the unsent upper bits so the head returns to 0.
            shreg <= '0;
            idx   <= '0;
        end else if (load) begin
            shreg <= word;
            idx   <= '0;
        end else if (advance) begin
            shreg <= shreg >> 1;
            idx   <= last_bit ? '0 : idx + IDX_W'(1);
        end
    end

    assign bit_out  = shreg[0];
    assign last_bit = (idx == IDX_W'(WORD_W - 1));

endmodule

// File: rtl/ccff_chain_loader.sv
// Initiator end of the ccff configuration chain: takes bitstream words over
// valid/ready and shifts them LSB-first onto the chain head.
// Optional readback compare of ccff_tail is enabled by CCFF_READBACK_EN.
//
// state | meaning
// IDLE  | out of reset, waiting for start
// FETCH | word_ready high, waiting for the next bitstream word
// SHIFT | one live bit on ccff_head per cycle, chain clock enabled
// DONE  | CHAIN_LEN bits shifted, done held until the next start
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter  int CHAIN_LEN = 4096,
    parameter  int WORD_W    = 8,
    localparam int CNT_W     = cnt_width(CHAIN_LEN)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              chain_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count
`ifdef CCFF_READBACK_EN
    ,
    input  logic              verify,
    output logic              mismatch,
    output logic [CNT_W-1:0]  mismatch_count
`endif
);

    state_t state_q;
    state_t state_d;
    logic   accept_start;
    logic   handshake;
    logic   shifting;
    logic   last_count;
    logic   last_bit;

    assign accept_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign handshake    = (state_q == ST_FETCH) && word_valid;
    assign shifting     = (state_q == ST_SHIFT);
    assign last_count   = (bit_count == CNT_W'(CHAIN_LEN - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE,
            ST_DONE:  if (start)      state_d = ST_FETCH;
            ST_FETCH: if (word_valid) state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (last_count)    state_d = ST_DONE;
                else if (last_bit) state_d = ST_FETCH;
            end
            default:               state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            bit_count <= '0;
        end else if (accept_start) begin
            bit_count <= '0;
        end else if (shifting && (bit_count != CNT_W'(CHAIN_LEN))) begin
            bit_count <= bit_count + CNT_W'(1);
        end
    end

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_serializer (
        .clk      (prog_clk),
        .rst_n    (pReset),
        .load     (handshake),
        .advance  (shifting),
        .clear    (shifting && last_count),
        .word     (word_in),
        .bit_out  (ccff_head),
        .last_bit (last_bit)
    );

    assign word_ready     = (state_q == ST_FETCH);
    assign chain_shift_en = shifting;
    assign busy           = (state_q == ST_FETCH) || (state_q == ST_SHIFT);
    assign done           = (state_q == ST_DONE);

`ifdef CCFF_READBACK_EN
    logic verify_q;

    // On a verify pass the tail presents the bit loaded at the same index last pass.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            verify_q       <= 1'b0;
            mismatch       <= 1'b0;
            mismatch_count <= '0;
        end else if (accept_start) begin
            verify_q       <= verify;
            mismatch       <= 1'b0;
            mismatch_count <= '0;
        end else if (shifting && verify_q && (ccff_tail != ccff_head)) begin
            mismatch <= 1'b1;
            if (mismatch_count != {CNT_W{1'b1}})
                mismatch_count <= mismatch_count + CNT_W'(1);
        end
    end
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: two instances (16-bit and 10-bit chains),
// scoreboarded ccff_head stream, readback checks under CCFF_READBACK_EN.
module tb_ccff_chain_loader;

    localparam int WW = 8;
    localparam int L0 = 16;
    localparam int L1 = 10;

    logic prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic          pReset;
    logic          start [2];
    logic          word_valid [2];
    logic          word_ready [2];
    logic          ccff_head [2];
    logic          chain_shift_en [2];
    logic          busy [2];
    logic          done [2];
    logic [WW-1:0] word_in [2];
    logic          tail0;
    logic          tail1;
    logic [4:0]    bc0;
    logic [3:0]    bc1;
`ifdef CCFF_READBACK_EN
    logic          verify [2];
    logic          mismatch [2];
    logic [4:0]    mc0;
    logic [3:0]    mc1;
`endif

    ccff_chain_loader #(.CHAIN_LEN(L0), .WORD_W(WW)) u_dut0 (
        .prog_clk       (prog_clk),
        .pReset         (pReset),
        .start          (start[0]),
        .word_in        (word_in[0]),
        .word_valid     (word_valid[0]),
        .word_ready     (word_ready[0]),
        .ccff_head      (ccff_head[0]),
        .chain_shift_en (chain_shift_en[0]),
        .ccff_tail      (tail0),
        .busy           (busy[0]),
        .done           (done[0]),
        .bit_count      (bc0)
`ifdef CCFF_READBACK_EN
        ,
        .verify         (verify[0]),
        .mismatch       (mismatch[0]),
        .mismatch_count (mc0)
`endif
    );

    ccff_chain_loader #(.CHAIN_LEN(L1), .WORD_W(WW)) u_dut1 (
        .prog_clk       (prog_clk),
        .pReset         (pReset),
        .start          (start[1]),
        .word_in        (word_in[1]),
        .word_valid     (word_valid[1]),
        .word_ready     (word_ready[1]),
        .ccff_head      (ccff_head[1]),
        .chain_shift_en (chain_shift_en[1]),
        .ccff_tail      (tail1),
        .busy           (busy[1]),
        .done           (done[1]),
        .bit_count      (bc1)
`ifdef CCFF_READBACK_EN
        ,
        .verify         (verify[1]),
        .mismatch       (mismatch[1]),
        .mismatch_count (mc1)
`endif
    );

    // Chain model for instance 0: a plain shift register clocked by the gate enable.
    logic [L0-1:0] chain = '0;
    always @(posedge prog_clk) if (chain_shift_en[0]) chain <= {ccff_head[0], chain[L0-1:1]};
    assign tail0 = chain[0];
    assign tail1 = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;
    int len [2] = '{L0, L1};
    int pushed [2];
    int shifts [2];
    bit q0 [$];
    bit q1 [$];
    bit e0, e1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int get_bc(input int d);
        return (d == 0) ? int'(bc0) : int'(bc1);
    endfunction

    always @(negedge prog_clk) if (pReset === 1'b1 && chain_shift_en[0] === 1'b1) begin
        shifts[0]++;
        if (q0.size() == 0) check_val("extra_shift0", 1, 0);
        else begin
            e0 = q0.pop_front();
            check_val("head0", ccff_head[0], e0);
        end
    end

    always @(negedge prog_clk) if (pReset === 1'b1 && chain_shift_en[1] === 1'b1) begin
        shifts[1]++;
        if (q1.size() == 0) check_val("extra_shift1", 1, 0);
        else begin
            e1 = q1.pop_front();
            check_val("head1", ccff_head[1], e1);
        end
    end

    task automatic push_word(input int d, input logic [WW-1:0] w);
        for (int b = 0; b < WW; b++) begin
            if (pushed[d] < len[d]) begin
                if (d == 0) q0.push_back(w[b]);
                else        q1.push_back(w[b]);
                pushed[d]++;
            end
        end
    endtask

    task automatic check_idle(input int d);
        check_val("rst_head", ccff_head[d], 0);
        check_val("rst_shift_en", chain_shift_en[d], 0);
        check_val("rst_ready", word_ready[d], 0);
        check_val("rst_busy", busy[d], 0);
        check_val("rst_done", done[d], 0);
        check_val("rst_bit_count", get_bc(d), 0);
    endtask

    task automatic pulse_start(input int d, input bit vfy);
        @(posedge prog_clk); #1;
        start[d] = 1'b1;
`ifdef CCFF_READBACK_EN
        verify[d] = vfy;
`else
        if (vfy) $display("note: verify requested without readback build");
`endif
        @(posedge prog_clk); #1;
        start[d] = 1'b0;
    endtask

    // Wait for word_ready, optionally hold valid low for stall FETCH cycles, then hand the word over.
    task automatic send_word(input int d, input logic [WW-1:0] w, input int stall, input int exp_wait);
        bit ok;
        int waited;
        int base;
        if (stall > 0) begin
            word_valid[d] = 1'b0;
            ok = 0;
            for (int t = 0; t < 100; t++) begin
                if (word_ready[d]) begin ok = 1; break; end
                @(negedge prog_clk);
            end
            check_val("stall_reach_fetch", ok, 1);
            base = get_bc(d);
            repeat (stall) begin
                @(negedge prog_clk);
                check_val("stall_shift_en", chain_shift_en[d], 0);
                check_val("stall_bit_count", get_bc(d), base);
            end
        end
        word_in[d]    = w;
        word_valid[d] = 1'b1;
        push_word(d, w);
        ok = 0;
        waited = 0;
        for (int t = 0; t < 100; t++) begin
            if (word_ready[d]) begin ok = 1; break; end
            @(negedge prog_clk);
            waited++;
        end
        check_val("handshake_timeout", ok, 1);
        if (exp_wait >= 0) check_val("word_bubble", waited, exp_wait);
        @(posedge prog_clk);
        @(negedge prog_clk);
        check_val("first_bit_latency", chain_shift_en[d], 1);
        check_val("ready_low_in_shift", word_ready[d], 0);
    endtask

    task automatic wait_done(input int d);
        bit ok = 0;
        for (int t = 0; t < 100; t++) begin
            if (done[d]) begin ok = 1; break; end
            @(negedge prog_clk);
        end
        check_val("done_timeout", ok, 1);
    endtask

    task automatic run_pass(input int d, input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                            input int stall, input bit vfy);
        shifts[d] = 0;
        pushed[d] = 0;
        pulse_start(d, vfy);
        check_val("start_busy", busy[d], 1);
        check_val("start_done_clr", done[d], 0);
        check_val("start_bit_count", get_bc(d), 0);
        check_val("start_ready", word_ready[d], 1);
        send_word(d, w0, 0, -1);
        send_word(d, w1, stall, (stall > 0) ? -1 : WW);
        word_valid[d] = 1'b0;
        wait_done(d);
        @(negedge prog_clk);
        check_val("pass_shift_cycles", shifts[d], len[d]);
        check_val("pass_bit_count", get_bc(d), len[d]);
        check_val("pass_done", done[d], 1);
        check_val("pass_busy", busy[d], 0);
        check_val("pass_head_idle", ccff_head[d], 0);
        check_val("pass_queue_empty", (d == 0) ? q0.size() : q1.size(), 0);
    endtask

    initial begin
        bit ok;
        pReset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; word_valid[d] = 1'b0; word_in[d] = '0;
            shifts[d] = 0; pushed[d] = 0;
`ifdef CCFF_READBACK_EN
            verify[d] = 1'b0;
`endif
        end
        repeat (3) @(posedge prog_clk);
        #1;
        check_idle(0);
        check_idle(1);
        @(negedge prog_clk);
        pReset = 1'b1;
        repeat (100) @(posedge prog_clk);
        #1;
        check_val("idle_no_shift", shifts[0] + shifts[1], 0);
        check_val("idle_busy", busy[0], 0);

        run_pass(0, 8'hA5, 8'h3C, 0, 1'b0);
        run_pass(1, 8'hFF, 8'h02, 0, 1'b0);
        run_pass(0, 8'hA5, 8'h3C, 5, 1'b0);

        // start during SHIFT is ignored, then an async reset lands on bit 7
        shifts[0] = 0;
        pushed[0] = 0;
        pulse_start(0, 1'b0);
        send_word(0, 8'hA5, 0, -1);
        word_valid[0] = 1'b0;
        @(posedge prog_clk); #1;
        start[0] = 1'b1;
        @(posedge prog_clk); #1;
        start[0] = 1'b0;
        check_val("ign_start_busy", busy[0], 1);
        check_val("ign_start_shift", chain_shift_en[0], 1);
        check_val("ign_start_count", bc0, 2);
        ok = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge prog_clk);
            if (bc0 == 5'd7) begin ok = 1; break; end
        end
        check_val("reach_bit7", ok, 1);
        #1 pReset = 1'b0;
        #1;
        check_idle(0);
        check_idle(1);
        q0.delete();
        @(negedge prog_clk);
        pReset = 1'b1;
        run_pass(0, 8'hA5, 8'h3C, 0, 1'b0);

`ifdef CCFF_READBACK_EN
        run_pass(0, 8'hA5, 8'h3C, 0, 1'b1);
        check_val("verify_same_mismatch", mismatch[0], 0);
        check_val("verify_same_count", mc0, 0);
        run_pass(0, 8'hA4, 8'h3C, 0, 1'b1);
        check_val("verify_diff_mismatch", mismatch[0], 1);
        check_val("verify_diff_count", mc0, 1);
        run_pass(0, 8'hA4, 8'h3C, 0, 1'b1);
        check_val("verify_clr_mismatch", mismatch[0], 0);
        check_val("verify_clr_count", mc0, 0);
`endif

        repeat (5) @(posedge prog_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
